// File: rtl/fp_pipe_pkg.sv
// Shared defaults for the FP pipeline registers: data/address widths and the
// destination-entry layout used by the write-back delay line.
package fp_pipe_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 4;
    localparam int WB_DEPTH_DEF = 4;

    // Default-width destination entry; modules with other widths declare their own.
    typedef struct packed {
        logic                  v;
        logic [ADDR_W_DEF-1:0] ad;
    } dest_ent_t;

    // Width needed to count 0..depth valid entries.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb_delay_line.sv
// Valid-tagged destination delay line from decode to write-back, with per-source
// RAW hazard compare against every stage and a registered in-flight count.
module wb_delay_line
    import fp_pipe_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WB_DEPTH = WB_DEPTH_DEF,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = cnt_w(WB_DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              adv,
    input  logic              ins_v,
    input  logic [ADDR_W-1:0] ins_ad,
    input  logic [ADDR_W-1:0] src1Ad,
    input  logic [ADDR_W-1:0] src2Ad,
    output logic [ADDR_W-1:0] ad0,
    output logic [ADDR_W-1:0] adp,
    output logic              wben,
    output logic              hazard1,
    output logic              hazard2,
    output logic [CNT_W-1:0]  inflight
);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] ad;
    } ent_t;

    ent_t [WB_DEPTH-1:0] stg;
    ent_t [WB_DEPTH-1:0] stg_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                zero_ins;
    logic                zero_s1;
    logic                zero_s2;

    // Address 0 as a null destination never enters the line as valid.
    assign zero_ins = (ZERO_REG != 0) && (ins_ad == '0);
    assign zero_s1  = (ZERO_REG != 0) && (src1Ad == '0);
    assign zero_s2  = (ZERO_REG != 0) && (src2Ad == '0);

    always_comb begin
        stg_nxt       = stg;
        stg_nxt[0].v  = ins_v & ~zero_ins;
        stg_nxt[0].ad = ins_ad;
        for (int k = 1; k < WB_DEPTH; k++)
            stg_nxt[k] = stg[k-1];
        cnt_nxt = '0;
        for (int k = 0; k < WB_DEPTH; k++)
            cnt_nxt = cnt_nxt + CNT_W'(stg_nxt[k].v);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stg      <= '0;
            inflight <= '0;
        end else if (adv) begin
            stg      <= stg_nxt;
            inflight <= cnt_nxt;
        end
    end

    // The last stage is compared too: the register file has no write-through.
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (stg[k].v && stg[k].ad == src1Ad) hazard1 = 1'b1;
            if (stg[k].v && stg[k].ad == src2Ad) hazard2 = 1'b1;
        end
        if (zero_s1) hazard1 = 1'b0;
        if (zero_s2) hazard2 = 1'b0;
    end

    assign ad0  = stg[0].ad;
    assign adp  = stg[WB_DEPTH-1].ad;
    assign wben = stg[WB_DEPTH-1].v;

endmodule

// File: rtl/pipe_stage_reg.sv
// ID/EX pipeline register: operand and source-address capture with enables,
// stage-0 valid, and the destination delay line down to write-back.
module pipe_stage_reg
    import fp_pipe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WB_DEPTH = WB_DEPTH_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           stall,
    input  logic                           flush,
    input  logic                           inValid,
    input  logic                           src1AdEn,
    input  logic                           src2AdEn,
    input  logic                           op1En,
    input  logic                           op2En,
    input  logic                           destAdEn,
    input  logic [ADDR_W-1:0]              src1Ad,
    input  logic [ADDR_W-1:0]              src2Ad,
    input  logic [ADDR_W-1:0]              destAd,
    input  logic [DATA_W-1:0]              op1,
    input  logic [DATA_W-1:0]              op2,
    output logic [ADDR_W-1:0]              src1Adp,
    output logic [ADDR_W-1:0]              src2Adp,
    output logic [DATA_W-1:0]              op1p,
    output logic [DATA_W-1:0]              op2p,
    output logic                           validp,
    output logic [ADDR_W-1:0]              destAd0,
    output logic [ADDR_W-1:0]              destAdp,
    output logic                           destWbEn,
    output logic                           hazard1,
    output logic                           hazard2,
    output logic [$clog2(WB_DEPTH+1)-1:0]  inflight
);

    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    logic adv;
    logic ins_v;

    assign adv   = ~stall;
    assign ins_v = inValid & destAdEn & ~flush;

    // Stall wins over flush: a flush seen during stall is simply lost.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            src1Adp <= '0;
            src2Adp <= '0;
            op1p    <= '0;
            op2p    <= '0;
            validp  <= 1'b0;
        end else if (adv) begin
            if (src1AdEn) src1Adp <= src1Ad;
            if (src2AdEn) src2Adp <= src2Ad;
            if (op1En)    op1p    <= op1;
            if (op2En)    op2p    <= op2;
            validp <= inValid & ~flush;
        end
    end

    wb_delay_line #(
        .ADDR_W   (ADDR_W),
        .WB_DEPTH (WB_DEPTH),
        .ZERO_REG (ZERO_REG),
        .CNT_W    (CNT_W)
    ) u_line (
        .Clock    (Clock),
        .Reset    (Reset),
        .adv      (adv),
        .ins_v    (ins_v),
        .ins_ad   (destAd),
        .src1Ad   (src1Ad),
        .src2Ad   (src2Ad),
        .ad0      (destAd0),
        .adp      (destAdp),
        .wben     (destWbEn),
        .hazard1  (hazard1),
        .hazard2  (hazard2),
        .inflight (inflight)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (ZERO_REG 0 and 1) on shared inputs,
// checked each cycle against a list-of-pending-writes model plus directed literals.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int WB = 4;
    localparam int CW = 3;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          stall = 0, flush = 0, inValid = 0;
    logic          src1AdEn = 0, src2AdEn = 0, op1En = 0, op2En = 0, destAdEn = 0;
    logic [AW-1:0] src1Ad = '0, src2Ad = '0, destAd = '0;
    logic [DW-1:0] op1 = '0, op2 = '0;

    logic [AW-1:0] src1Adp, src2Adp, destAd0, destAdp;
    logic [DW-1:0] op1p, op2p;
    logic          validp, destWbEn, hazard1, hazard2;
    logic [CW-1:0] inflight;

    logic [AW-1:0] src1Adp_z, src2Adp_z, destAd0_z, destAdp_z;
    logic [DW-1:0] op1p_z, op2p_z;
    logic          validp_z, destWbEn_z, hazard1_z, hazard2_z;
    logic [CW-1:0] inflight_z;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    pipe_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .WB_DEPTH(WB), .ZERO_REG(0)) dut (
        .Clock(Clock), .Reset(Reset), .stall(stall), .flush(flush), .inValid(inValid),
        .src1AdEn(src1AdEn), .src2AdEn(src2AdEn), .op1En(op1En), .op2En(op2En),
        .destAdEn(destAdEn), .src1Ad(src1Ad), .src2Ad(src2Ad), .destAd(destAd),
        .op1(op1), .op2(op2), .src1Adp(src1Adp), .src2Adp(src2Adp), .op1p(op1p),
        .op2p(op2p), .validp(validp), .destAd0(destAd0), .destAdp(destAdp),
        .destWbEn(destWbEn), .hazard1(hazard1), .hazard2(hazard2), .inflight(inflight));

    pipe_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .WB_DEPTH(WB), .ZERO_REG(1)) dutz (
        .Clock(Clock), .Reset(Reset), .stall(stall), .flush(flush), .inValid(inValid),
        .src1AdEn(src1AdEn), .src2AdEn(src2AdEn), .op1En(op1En), .op2En(op2En),
        .destAdEn(destAdEn), .src1Ad(src1Ad), .src2Ad(src2Ad), .destAd(destAd),
        .op1(op1), .op2(op2), .src1Adp(src1Adp_z), .src2Adp(src2Adp_z), .op1p(op1p_z),
        .op2p(op2p_z), .validp(validp_z), .destAd0(destAd0_z), .destAdp(destAdp_z),
        .destWbEn(destWbEn_z), .hazard1(hazard1_z), .hazard2(hazard2_z),
        .inflight(inflight_z));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: each issued write is a record with an age in advancing cycles; it is
    // visible to write-back at age WB-1 and gone at age WB. in0/in1 say whether it
    // counts for the ZERO_REG=0 / ZERO_REG=1 instance.
    typedef struct {
        int ad;
        int age;
        bit in0;
        bit in1;
    } wr_t;

    wr_t           wq[$];
    wr_t           nq[$];
    wr_t           e;
    int            hist[WB];
    logic [DW-1:0] m_op1 = '0, m_op2 = '0;
    logic [AW-1:0] m_s1 = '0, m_s2 = '0;
    logic          m_val = 1'b0;

    always begin
        @(posedge Clock or posedge Reset);
        if (Reset) begin
            wq.delete();
            for (int i = 0; i < WB; i++) hist[i] = 0;
            m_op1 = '0; m_op2 = '0; m_s1 = '0; m_s2 = '0; m_val = 1'b0;
        end else if (!stall) begin
            nq.delete();
            foreach (wq[i]) begin
                e = wq[i];
                e.age = e.age + 1;
                if (e.age < WB) nq.push_back(e);
            end
            if (inValid && destAdEn && !flush) begin
                e.ad  = int'(destAd);
                e.age = 0;
                e.in0 = 1'b1;
                e.in1 = (destAd != 0);
                if (e.in0 || e.in1) nq.push_back(e);
            end
            wq = nq;
            for (int i = WB - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(destAd);
            if (op1En)    m_op1 = op1;
            if (op2En)    m_op2 = op2;
            if (src1AdEn) m_s1  = src1Ad;
            if (src2AdEn) m_s2  = src2Ad;
            m_val = inValid && !flush;
        end
    end

    function automatic logic m_wb(input bit z);
        logic r = 1'b0;
        foreach (wq[i]) if ((z ? wq[i].in1 : wq[i].in0) && wq[i].age == WB - 1) r = 1'b1;
        return r;
    endfunction

    function automatic int m_cnt(input bit z);
        int n = 0;
        foreach (wq[i]) if (z ? wq[i].in1 : wq[i].in0) n++;
        return n;
    endfunction

    function automatic logic m_haz(input bit z, input logic [AW-1:0] s);
        logic r = 1'b0;
        foreach (wq[i]) if ((z ? wq[i].in1 : wq[i].in0) && wq[i].ad == int'(s)) r = 1'b1;
        if (z && s == 0) r = 1'b0;
        return r;
    endfunction

    always @(negedge Clock) begin
        if (!Reset) begin
            chk("op1p",      64'(op1p),       64'(m_op1));
            chk("op2p",      64'(op2p),       64'(m_op2));
            chk("src1Adp",   64'(src1Adp),    64'(m_s1));
            chk("src2Adp",   64'(src2Adp),    64'(m_s2));
            chk("validp",    64'(validp),     64'(m_val));
            chk("destAd0",   64'(destAd0),    64'(hist[0]));
            chk("destAdp",   64'(destAdp),    64'(hist[WB-1]));
            chk("destWbEn",  64'(destWbEn),   64'(m_wb(0)));
            chk("hazard1",   64'(hazard1),    64'(m_haz(0, src1Ad)));
            chk("hazard2",   64'(hazard2),    64'(m_haz(0, src2Ad)));
            chk("inflight",  64'(inflight),   64'(m_cnt(0)));
            chk("z_validp",  64'(validp_z),   64'(m_val));
            chk("z_destAd0", 64'(destAd0_z),  64'(hist[0]));
            chk("z_destAdp", 64'(destAdp_z),  64'(hist[WB-1]));
            chk("z_destWbEn",64'(destWbEn_z), 64'(m_wb(1)));
            chk("z_hazard1", 64'(hazard1_z),  64'(m_haz(1, src1Ad)));
            chk("z_hazard2", 64'(hazard2_z),  64'(m_haz(1, src2Ad)));
            chk("z_inflight",64'(inflight_z), 64'(m_cnt(1)));
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        inValid = 0; destAdEn = 0; flush = 0; stall = 0;
        op1En = 0; op2En = 0; src1AdEn = 0; src2AdEn = 0;
    endtask

    task automatic inject(input logic [AW-1:0] a);
        destAd = a; inValid = 1; destAdEn = 1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_op1p"},     64'(op1p),       64'h0);
        chk({tag, "_src1Adp"},  64'(src1Adp),    64'h0);
        chk({tag, "_validp"},   64'(validp),     64'h0);
        chk({tag, "_destAd0"},  64'(destAd0),    64'h0);
        chk({tag, "_destAdp"},  64'(destAdp),    64'h0);
        chk({tag, "_destWbEn"}, 64'(destWbEn),   64'h0);
        chk({tag, "_hazard1"},  64'(hazard1),    64'h0);
        chk({tag, "_inflight"}, 64'(inflight),   64'h0);
        chk({tag, "_z_inflight"}, 64'(inflight_z), 64'h0);
    endtask

    int peak, nwb, zwb;

    initial begin
        repeat (2) @(posedge Clock);
        #1;
        chk_all_zero("por");
        Reset = 0;

        // Latency: write-back exactly WB edges after injection
        inject(4'h5); op1 = 32'h1111_0000; op1En = 1;
        step();
        idle();
        step(); step();
        chk("lat_wb_early", 64'(destWbEn), 64'h0);
        step();
        chk("lat_wb", 64'(destWbEn), 64'h1);
        chk("lat_ad", 64'(destAdp), 64'h5);
        step();

        // Stall in mid-line: two frozen cycles push write-back to edge 6
        inject(4'h5); op1 = 32'hAAAA_AAAA; op1En = 1;
        step();
        idle();
        step();
        stall = 1; op1 = 32'hBBBB_BBBB; op1En = 1;
        step(); step();
        chk("stall_op1_hold", 64'(op1p), 64'hAAAA_AAAA);
        stall = 0; op1En = 0;
        step();
        chk("stall_wb_early", 64'(destWbEn), 64'h0);
        step();
        chk("stall_wb", 64'(destWbEn), 64'h1);
        chk("stall_ad", 64'(destAdp), 64'h5);
        step();

        // Flush kills only the entering instruction
        inject(4'h3);
        step();
        peak = int'(inflight); nwb = 0;
        inject(4'h7); flush = 1;
        step();
        chk("flush_validp", 64'(validp), 64'h0);
        idle();
        for (int i = 0; i < 6; i++) begin
            if (int'(inflight) > peak) peak = int'(inflight);
            if (destWbEn) begin
                nwb++;
                chk("flush_wb_ad", 64'(destAdp), 64'h3);
            end
            step();
        end
        chk("flush_peak", 64'(peak), 64'h1);
        chk("flush_nwb", 64'(nwb), 64'h1);

        // Hazard at stage 2 and through write-back, clear after retirement
        src1Ad = 4'h9; src2Ad = 4'h2;
        inject(4'h9);
        step();
        idle();
        step(); step();
        chk("haz_s2_h1", 64'(hazard1), 64'h1);
        chk("haz_s2_h2", 64'(hazard2), 64'h0);
        step();
        chk("haz_s3_h1", 64'(hazard1), 64'h1);
        step();
        chk("haz_ret_h1", 64'(hazard1), 64'h0);

        // Null destination on the ZERO_REG instance
        inject(4'h0);
        step();
        idle();
        src1Ad = 4'h0;
        #1;
        chk("zr_haz_z", 64'(hazard1_z), 64'h0);
        chk("zr_haz_n", 64'(hazard1),   64'h1);
        zwb = 0; nwb = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (destWbEn_z) zwb++;
            if (destWbEn) nwb++;
        end
        chk("zr_wb_z", 64'(zwb), 64'h0);
        chk("zr_wb_n", 64'(nwb), 64'h1);

        // Back-to-back writes fill the line
        for (int a = 1; a <= 4; a++) begin
            inject(4'(a));
            step();
        end
        chk("full_inflight_z", 64'(inflight_z), 64'h4);
        chk("full_inflight",   64'(inflight),   64'h4);

        // Mid-cycle reset with every input nonzero
        stall = 1; flush = 1; inValid = 1; destAdEn = 1;
        src1AdEn = 1; src2AdEn = 1; op1En = 1; op2En = 1;
        src1Ad = 4'h3; src2Ad = 4'h4; destAd = 4'hF;
        op1 = 32'hDEAD_BEEF; op2 = 32'hCAFE_F00D;
        @(posedge Clock);
        #3 Reset = 1;
        #1 chk_all_zero("rst");
        chk("rst_hazard2", 64'(hazard2), 64'h0);
        idle();
        #2 Reset = 0;
        step();
        chk("post_rst_wb", 64'(destWbEn), 64'h0);
        chk("post_rst_valid", 64'(validp), 64'h0);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
